// File: rtl/pdm_multi_channel.sv
// pdm_multi_channel
//   Multi-channel first-order PDM (sigma-delta) DAC on a Wishbone bus, with a
//   per-channel enable mask and a shared slew limiter that ramps each
//   channel's live level one step per tick toward its written target.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wb_stb, wb_we   Wishbone strobe / write enable (zero wait states)
//   wb_adr          register address: 0..7 target, 8..15 current (RO),
//                   16 enable mask, 17 slew_div; everything else reads 0
//   wb_dat_i        write data
//   wb_dat_o        combinational read data
//   wb_ack          acknowledge (= wb_stb)
//   pdm             one PDM bitstream per channel
//   settled         every enabled channel has current == target
module pdm_multi_channel #(
  parameter int BITS     = 8,
  parameter int CHANNELS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_stb,
  input  logic                wb_we,
  input  logic [4:0]          wb_adr,
  input  logic [15:0]         wb_dat_i,
  output logic [15:0]         wb_dat_o,
  output logic                wb_ack,
  output logic [CHANNELS-1:0] pdm,
  output logic                settled
);

  logic [CHANNELS*BITS-1:0] target_flat;
  logic [CHANNELS*BITS-1:0] current_flat;
  logic [CHANNELS-1:0]      at_target;
  logic [CHANNELS-1:0]      enable;
  logic [15:0]              slew_div;
  logic [15:0]              prescaler;
  logic                     wr;
  logic                     bypass;
  logic                     tick;

  assign wr     = wb_stb & wb_we;
  assign wb_ack = wb_stb;
  assign bypass = (slew_div == '0);
  assign tick   = !bypass && (prescaler == slew_div - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      enable    <= '0;
      slew_div  <= '0;
      prescaler <= '0;
    end else begin
      if (wr && wb_adr == 5'd16) enable <= wb_dat_i[CHANNELS-1:0];
      if (wr && wb_adr == 5'd17) begin
        slew_div  <= wb_dat_i;
        prescaler <= '0;
      end else if (bypass || tick) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [BITS-1:0] target_q;
    logic [BITS-1:0] current_q;
    logic [BITS:0]   acc_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        target_q  <= '0;
        current_q <= '0;
        acc_q     <= '0;
      end else begin
        if (wr && wb_adr == 5'(g)) target_q <= wb_dat_i[BITS-1:0];
        if (!enable[g]) begin
          current_q <= '0;
          acc_q     <= '0;
        end else begin
          // Carry out of the BITS-wide sum is the PDM bit; only the low
          // BITS are fed back.
          acc_q <= {1'b0, acc_q[BITS-1:0]} + {1'b0, current_q};
          if (bypass) begin
            current_q <= target_q;
          end else if (tick && current_q != target_q) begin
            current_q <= (current_q < target_q) ? current_q + BITS'(1)
                                                : current_q - BITS'(1);
          end
        end
      end
    end

    assign target_flat[g*BITS +: BITS]  = target_q;
    assign current_flat[g*BITS +: BITS] = current_q;
    assign at_target[g]                 = (current_q == target_q);
    assign pdm[g]                       = acc_q[BITS];
  end

  assign settled = &(~enable | at_target);

  always_comb begin
    wb_dat_o = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (wb_adr == 5'(i))     wb_dat_o[BITS-1:0] = target_flat[i*BITS +: BITS];
      if (wb_adr == 5'(i + 8)) wb_dat_o[BITS-1:0] = current_flat[i*BITS +: BITS];
    end
    if (wb_adr == 5'd16) wb_dat_o[CHANNELS-1:0] = enable;
    if (wb_adr == 5'd17) wb_dat_o = slew_div;
  end

endmodule

// File: tb/tb_pdm_multi_channel.sv
module tb_pdm_multi_channel;
  localparam int BITS = 8;
  localparam int CH   = 4;
  localparam int ONE  = 1 << BITS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wb_stb = 1'b0;
  logic          wb_we = 1'b0;
  logic [4:0]    wb_adr = '0;
  logic [15:0]   wb_dat_i = '0;
  logic [15:0]   wb_dat_o;
  logic          wb_ack;
  logic [CH-1:0] pdm;
  logic          settled;

  pdm_multi_channel #(.BITS(BITS), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .pdm(pdm),
    .settled(settled)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integer state stepped once per clock.
  int m_tgt[CH];
  int m_cur[CH];
  int m_acc[CH];
  int m_en, m_div, m_pre;
  bit mvalid = 0;

  logic [CH-1:0] s_pdm;
  logic [15:0]   s_rd;
  logic          s_settled;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_enabled(input int i);
    return ((m_en >> i) & 1) != 0;
  endfunction

  function automatic logic [15:0] m_read(input int a);
    if (a < 8)   return (a < CH) ? 16'(m_tgt[a]) : 16'h0;
    if (a < 16)  return (a - 8 < CH) ? 16'(m_cur[a-8]) : 16'h0;
    if (a == 16) return 16'(m_en);
    if (a == 17) return 16'(m_div);
    return 16'h0;
  endfunction

  function automatic logic [15:0] m_pdm();
    logic [15:0] p = '0;
    for (int i = 0; i < CH; i++) if (m_acc[i] >= ONE) p[i] = 1'b1;
    return p;
  endfunction

  function automatic logic [15:0] m_settled();
    for (int i = 0; i < CH; i++)
      if (m_enabled(i) && m_cur[i] != m_tgt[i]) return 16'h0;
    return 16'h1;
  endfunction

  function automatic void m_step(input bit r, input bit stb, input bit we,
                                 input int a, input int d);
    bit wr, tk;
    if (r) begin
      for (int i = 0; i < CH; i++) begin m_tgt[i] = 0; m_cur[i] = 0; m_acc[i] = 0; end
      m_en = 0; m_div = 0; m_pre = 0; mvalid = 1;
      return;
    end
    wr = stb && we;
    tk = (m_div != 0) && (m_pre == m_div - 1);
    for (int i = 0; i < CH; i++) begin
      if (!m_enabled(i)) begin
        m_cur[i] = 0; m_acc[i] = 0;
      end else begin
        m_acc[i] = (m_acc[i] % ONE) + m_cur[i];
        if (m_div == 0) m_cur[i] = m_tgt[i];
        else if (tk && m_tgt[i] > m_cur[i]) m_cur[i]++;
        else if (tk && m_tgt[i] < m_cur[i]) m_cur[i]--;
      end
    end
    if (wr && a == 17)            m_pre = 0;
    else if (m_div == 0 || tk)    m_pre = 0;
    else                          m_pre++;
    if (wr) begin
      if (a < CH)   m_tgt[a] = d % ONE;
      if (a == 16)  m_en  = d & ((1 << CH) - 1);
      if (a == 17)  m_div = d;
    end
  endfunction

  // One bus cycle: drive, compare against model, clock, advance model.
  task automatic do_cycle(input bit r, input bit stb, input bit we,
                          input logic [4:0] a, input logic [15:0] d);
    rst = r; wb_stb = stb; wb_we = we; wb_adr = a; wb_dat_i = d;
    #1;
    s_pdm = pdm; s_rd = wb_dat_o; s_settled = settled;
    if (mvalid) begin
      check("ack", 16'(wb_ack), 16'(stb));
      check("rdata", wb_dat_o, m_read(int'(a)));
      check("pdm", 16'(pdm), m_pdm());
      check("settled", 16'(settled), m_settled());
    end
    @(posedge clk);
    m_step(r, stb, we, int'(a), int'(d));
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    do_cycle(0, 1, 1, a, d);
  endtask
  task automatic rd(input logic [4:0] a);
    do_cycle(0, 1, 0, a, 16'h0);
  endtask
  task automatic reset();
    do_cycle(1, 0, 0, 5'd0, 16'h0);
  endtask

  typedef struct {
    logic [4:0]  adr;
    logic [15:0] wdat;
    logic [15:0] exp;
  } map_vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    map_vec_t vecs[7];
    int cnt, win, maxwin, minv;
    bit found;
    logic [3:0] hist;
    int unsigned op;
    logic [4:0]  ra;
    logic [15:0] rdat;

    vecs[0] = '{5'd5,  16'hABCD, 16'h0000};
    vecs[1] = '{5'd17, 16'h1234, 16'h1234};
    vecs[2] = '{5'd0,  16'hFFFF, 16'h00FF};
    vecs[3] = '{5'd16, 16'hFFFF, 16'h000F};
    vecs[4] = '{5'd20, 16'h5555, 16'h0000};
    vecs[5] = '{5'd13, 16'hFFFF, 16'h0000};
    vecs[6] = '{5'd3,  16'h0180, 16'h0080};

    @(negedge clk);
    reset();
    rd(5'd0);
    check("reset_settled", 16'(s_settled), 16'h1);
    check("reset_pdm", 16'(s_pdm), 16'h0);

    // Bypass mode: level follows target one cycle later, duty 64/256.
    wr(5'd16, 16'h1);
    wr(5'd0, 16'd64);
    rd(5'd8);
    rd(5'd8);
    check("bypass_current", s_rd, 16'd64);
    rd(5'd8);
    cnt = 0; maxwin = 0; hist = '0;
    for (int i = 0; i < 256; i++) begin
      rd(5'd8);
      cnt += int'(s_pdm[0]);
      hist = {hist[2:0], s_pdm[0]};
      win = int'(hist[0]) + int'(hist[1]) + int'(hist[2]) + int'(hist[3]);
      if (win > maxwin) maxwin = win;
    end
    check("duty_64_of_256", 16'(cnt), 16'd64);
    check("max_one_in_4", 16'(maxwin), 16'd1);

    // Slew ramp up then down, no overshoot.
    reset();
    wr(5'd17, 16'd4);
    wr(5'd1, 16'd10);
    wr(5'd16, 16'h2);
    repeat (8) rd(5'd9);
    check("ramp_not_settled", 16'(s_settled), 16'h0);
    repeat (40) rd(5'd9);
    check("ramp_up_done", s_rd, 16'd10);
    check("ramp_up_settled", 16'(s_settled), 16'h1);
    wr(5'd1, 16'd7);
    minv = 255;
    for (int i = 0; i < 16; i++) begin
      rd(5'd9);
      if (int'(s_rd) < minv) minv = int'(s_rd);
    end
    check("ramp_down_done", s_rd, 16'd7);
    check("no_overshoot", 16'(minv >= 7), 16'h1);

    // Disable mid-ramp, then re-enable restarts from 0.
    reset();
    wr(5'd17, 16'd4);
    wr(5'd0, 16'd200);
    wr(5'd16, 16'h1);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      rd(5'd8);
      if (s_rd == 16'd5) found = 1;
    end
    check("reach_5", 16'(found), 16'h1);
    wr(5'd16, 16'h0);
    rd(5'd8);
    rd(5'd8);
    check("disabled_current", s_rd, 16'h0);
    check("disabled_pdm", 16'(s_pdm[0]), 16'h0);
    wr(5'd16, 16'h1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      rd(5'd8);
      if (s_rd != 16'h0) found = 1;
    end
    check("restart_first_step", s_rd, 16'd1);

    // Target write on a tick cycle: step toward old target, then new.
    reset();
    wr(5'd17, 16'd4);
    wr(5'd2, 16'd10);
    wr(5'd16, 16'h4);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      rd(5'd10);
      if (s_rd == 16'd3) found = 1;
    end
    check("reach_3", 16'(found), 16'h1);
    for (int i = 0; i < 8 && m_pre != 3; i++) rd(5'd10);
    wr(5'd2, 16'd0);
    rd(5'd10);
    check("tick_uses_old_target", s_rd, 16'd4);
    repeat (3) rd(5'd10);
    rd(5'd10);
    check("next_tick_new_target", s_rd, 16'd3);

    // Register map vectors.
    reset();
    foreach (vecs[i]) begin
      wr(vecs[i].adr, vecs[i].wdat);
      rd(vecs[i].adr);
      check($sformatf("map_adr%0d", vecs[i].adr), s_rd, vecs[i].exp);
    end

    // Reset mid-ramp with all channels active.
    reset();
    wr(5'd17, 16'd2);
    wr(5'd0, 16'd100);
    wr(5'd1, 16'd50);
    wr(5'd2, 16'd30);
    wr(5'd3, 16'd1);
    wr(5'd16, 16'hF);
    repeat (10) rd(5'd8);
    reset();
    rd(5'd0);
    check("rst_pdm", 16'(s_pdm), 16'h0);
    check("rst_settled", 16'(s_settled), 16'h1);
    check("rst_target0", s_rd, 16'h0);
    rd(5'd8);  check("rst_current0", s_rd, 16'h0);
    rd(5'd16); check("rst_enable", s_rd, 16'h0);
    rd(5'd17); check("rst_slew_div", s_rd, 16'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      op   = $urandom_range(0, 199);
      ra   = 5'($urandom_range(0, 31));
      rdat = 16'($urandom);
      if (ra == 5'd17) rdat = 16'($urandom_range(0, 6));
      if (op < 1)        reset();
      else if (op < 50)  wr(ra, rdat);
      else if (op < 160) rd(ra);
      else               do_cycle(0, 0, 1'($urandom_range(0, 1)), ra, rdat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
